// File: rtl/handshake_fixed_pkg.sv
// rtl/handshake_fixed_pkg.sv - shared fixed-point defaults and constants
// Purpose: default operand geometry, saturation limits and the softclip
//          coefficient shared by the constant stages and the multiplier.
// Ports:   none (package).
package handshake_fixed_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_FRAC_BITS  = 20;

  // Largest and smallest representable values for the default width.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEFAULT_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEFAULT_DATA_WIDTH-1){1'b0}}};

  // Softclip coefficient, Q3.20, approximately -0.5887.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] SOFTCLIP_COEFF = 24'hF694C2;

endpackage

// File: rtl/handshake_join_2.sv
// rtl/handshake_join_2.sv - two-input valid/ready join gated by a pipeline enable
// Purpose: a token fires only when both inputs are valid and the pipeline can
//          advance; each side is consumed only together with the other.
// Ports:   i_a_valid, i_b_valid - input token present
//          i_en                 - pipeline advance enable
//          o_fire               - both tokens consumed this cycle
//          o_a_ready, o_b_ready - per-side ready, each depends on the other valid
module handshake_join_2 (
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_en,
  output logic o_fire,
  output logic o_a_ready,
  output logic o_b_ready
);

  assign o_a_ready = i_en & i_b_valid;
  assign o_b_ready = i_en & i_a_valid;
  assign o_fire    = i_en & i_a_valid & i_b_valid;

endmodule

// File: rtl/handshake_mulfix_sat.sv
// rtl/handshake_mulfix_sat.sv - elastic 3-stage signed fixed-point multiplier with saturation
// Purpose: joins lhs and rhs tokens, multiplies, rescales by FRAC_BITS (floor)
//          and saturates to DATA_WIDTH. Fixed 3-cycle latency, full throughput,
//          whole pipeline stalls when the output is held.
// Ports:   clk                            - clock
//          rst                            - asynchronous active-low reset
//          lhs, lhs_valid, lhs_ready      - data operand channel
//          rhs, rhs_valid, rhs_ready      - coefficient operand channel
//          outs, outs_valid, outs_ready   - saturated product channel
module handshake_mulfix_sat
  import handshake_fixed_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] L_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] L_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                         w_en;
  logic                         w_fire;
  logic                         r_v0;
  logic                         r_v1;
  logic                         r_v2;
  logic signed [DATA_WIDTH-1:0] r_lhs;
  logic signed [DATA_WIDTH-1:0] r_rhs;
  logic signed [PW-1:0]         r_prod;
  logic [DATA_WIDTH-1:0]        r_out;
  logic signed [PW-1:0]         w_shifted;
  logic [DATA_WIDTH:0]          w_upper;
  logic [DATA_WIDTH-1:0]        w_sat;

  // Global stall: the only thing that can hold the pipe is a held output.
  assign w_en = outs_ready | ~r_v2;

  handshake_join_2 u_join (
    .i_a_valid (lhs_valid),
    .i_b_valid (rhs_valid),
    .i_en      (w_en),
    .o_fire    (w_fire),
    .o_a_ready (lhs_ready),
    .o_b_ready (rhs_ready)
  );

  // Arithmetic shift floors toward minus infinity; no rounding bit.
  assign w_shifted = r_prod >>> FRAC_BITS;

  // The value fits in DATA_WIDTH iff the top PW-DATA_WIDTH+1 bits are all
  // copies of the result sign bit.
  assign w_upper = w_shifted[PW-1:DATA_WIDTH-1];

  always_comb begin
    w_sat = w_shifted[DATA_WIDTH-1:0];
    if (!((&w_upper) || !(|w_upper))) begin
      w_sat = w_shifted[PW-1] ? L_SAT_MIN : L_SAT_MAX;
    end
  end

  // Data registers load on every enabled cycle; only the valid bits matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_lhs  <= '0;
      r_rhs  <= '0;
      r_prod <= '0;
      r_out  <= '0;
    end else if (w_en) begin
      r_v0   <= w_fire;
      r_lhs  <= lhs;
      r_rhs  <= rhs;
      r_v1   <= r_v0;
      r_prod <= r_lhs * r_rhs;
      r_v2   <= r_v1;
      r_out  <= w_sat;
    end
  end

  assign outs       = r_out;
  assign outs_valid = r_v2;

endmodule

// File: tb/tb_handshake_mulfix_sat.sv
// tb/tb_handshake_mulfix_sat.sv - directed self-checking bench for handshake_mulfix_sat
module tb_handshake_mulfix_sat;
  import handshake_fixed_pkg::*;

  logic        clk;
  logic        rst;
  logic [23:0] lhs;
  logic        lhs_valid;
  logic        lhs_ready;
  logic [23:0] rhs;
  logic        rhs_valid;
  logic        rhs_ready;
  logic [23:0] outs;
  logic        outs_valid;
  logic        outs_ready;

  int n_checks = 0;
  int n_err    = 0;

  handshake_mulfix_sat dut (
    .clk        (clk),
    .rst        (rst),
    .lhs        (lhs),
    .lhs_valid  (lhs_valid),
    .lhs_ready  (lhs_ready),
    .rhs        (rhs),
    .rhs_valid  (rhs_valid),
    .rhs_ready  (rhs_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact 64-bit product, floor shift, clamp to 24-bit range.
  function automatic logic [23:0] model(input logic [23:0] a, input logic [23:0] b);
    longint p;
    longint s;
    logic [63:0] sv;
    p = longint'($signed(a)) * longint'($signed(b));
    s = p >>> 20;
    if (s > 64'sd8388607) return 24'h7FFFFF;
    if (s < -64'sd8388608) return 24'h800000;
    sv = s;
    return sv[23:0];
  endfunction

  // Single token into an empty pipe; result must appear exactly 3 cycles later.
  task automatic run_one(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp);
    lhs = a; rhs = b; lhs_valid = 1'b1; rhs_valid = 1'b1; outs_ready = 1'b1;
    #1;
    chk({tag, "_lhs_ready"}, lhs_ready, 1);
    chk({tag, "_rhs_ready"}, rhs_ready, 1);
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    #1;
    chk({tag, "_lat1_valid"}, outs_valid, 0);
    tick(); #1;
    chk({tag, "_lat2_valid"}, outs_valid, 0);
    tick(); #1;
    chk({tag, "_lat3_valid"}, outs_valid, 1);
    chk({tag, "_data"}, outs, exp);
    tick(); #1;
    chk({tag, "_drain_valid"}, outs_valid, 0);
  endtask

  logic [23:0] va[10];
  logic [23:0] vb[10];
  logic [23:0] exp_q[$];
  logic [23:0] prev_out;
  logic        prev_stall;
  int          sent;
  int          rcvd;
  int          first_cyc;
  int          last_cyc;

  initial begin
    va = '{24'h100000, 24'h400000, 24'hC00000, 24'h000001, 24'hFFFFFF,
           24'h7FFFFF, 24'h800000, 24'h0A0000, 24'hF00000, 24'h123456};
    vb = '{SOFTCLIP_COEFF, 24'h400000, 24'h400000, 24'hFFFFFF, 24'h000001,
           24'h7FFFFF, 24'h7FFFFF, SOFTCLIP_COEFF, 24'h080000, 24'hF00000};

    rst = 1'b0; lhs = '0; rhs = '0; lhs_valid = 1'b0; rhs_valid = 1'b0; outs_ready = 1'b0;
    tick(); tick();
    chk("reset_outs_valid", outs_valid, 0);
    chk("reset_outs", outs, 0);
    chk("reset_lhs_ready", lhs_ready, 0);
    chk("reset_rhs_ready", rhs_ready, 0);
    rst = 1'b1;
    tick();

    run_one("identity", 24'h100000, SOFTCLIP_COEFF, 24'hF694C2);
    run_one("sat_pos", 24'h400000, 24'h400000, 24'h7FFFFF);
    run_one("sat_neg", 24'h400000, 24'hC00000, 24'h800000);
    run_one("floor_neg", 24'h000001, 24'hFFFFFF, 24'hFFFFFF);
    run_one("floor_pos", 24'h000001, 24'h000001, 24'h000000);

    // Join: lhs alone must never be consumed.
    lhs = 24'h100000; rhs = 24'h080000; lhs_valid = 1'b1; rhs_valid = 1'b0; outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("join_lhs_ready_low", lhs_ready, 0);
      chk("join_rhs_ready_high", rhs_ready, 1);
      chk("join_no_output", outs_valid, 0);
      tick();
    end
    rhs_valid = 1'b1;
    #1;
    chk("join_lhs_ready_fire", lhs_ready, 1);
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    tick(); #1;
    chk("join_lat2_valid", outs_valid, 0);
    tick(); #1;
    chk("join_result_valid", outs_valid, 1);
    chk("join_result_data", outs, 24'h080000);
    tick();

    // Back-to-back stream with random backpressure against the model.
    sent = 0; rcvd = 0; prev_stall = 1'b0; prev_out = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
      if (sent < 10) begin
        lhs = va[sent]; rhs = vb[sent]; lhs_valid = 1'b1; rhs_valid = 1'b1;
      end else begin
        lhs_valid = 1'b0; rhs_valid = 1'b0;
      end
      outs_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) chk("bp_stall_stable", outs, prev_out);
      chk("bp_ready_join", lhs_ready, (outs_ready || !outs_valid) && rhs_valid);
      if (lhs_valid && lhs_ready) begin
        exp_q.push_back(model(lhs, rhs));
        sent++;
      end
      if (outs_valid && outs_ready) begin
        chk("bp_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("bp_data", outs, exp_q.pop_front());
        rcvd++;
      end
      prev_stall = outs_valid && !outs_ready;
      prev_out = outs;
      tick();
    end
    chk("bp_received_count", rcvd, 10);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Constant ready: 10 results in 10 consecutive cycles.
    lhs_valid = 1'b0; rhs_valid = 1'b0; outs_ready = 1'b1;
    tick(); tick(); tick(); tick();
    exp_q.delete();
    sent = 0; rcvd = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 10) begin
        lhs = va[sent]; rhs = vb[sent]; lhs_valid = 1'b1; rhs_valid = 1'b1;
      end else begin
        lhs_valid = 1'b0; rhs_valid = 1'b0;
      end
      #1;
      if (lhs_valid && lhs_ready) begin
        exp_q.push_back(model(lhs, rhs));
        sent++;
      end
      if (outs_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("tp_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tp_data", outs, exp_q.pop_front());
        rcvd++;
      end
      tick();
    end
    chk("tp_count", rcvd, 10);
    chk("tp_first_cycle", first_cyc, 3);
    chk("tp_last_cycle", last_cyc, 12);

    // Reset with three tokens in flight, output stalled.
    outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lhs = va[i]; rhs = vb[i]; lhs_valid = 1'b1; rhs_valid = 1'b1;
      tick();
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0; outs_ready = 1'b0;
    #1;
    chk("rst_pre_valid", outs_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", outs_valid, 0);
    chk("rst_async_outs", outs, 0);
    tick(); tick();
    #2;
    rst = 1'b1;
    lhs = 24'h200000; lhs_valid = 1'b1; rhs_valid = 1'b0; outs_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_no_stale", outs_valid, 0);
      chk("post_rst_lhs_ready", lhs_ready, 0);
      tick();
    end
    run_one("post_rst_token", 24'h200000, 24'h180000, 24'h300000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
